// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stage indices, FSM encodings,
// the default watchdog timeout and a helper to build contiguous stage masks.
package pipe_ctrl_pkg;

  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam int NSTG      = 5;

  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Mask with bits lo..hi set, e.g. stg_range(STG_PC, STG_EXMEM) = 5'b01111.
  function automatic logic [NSTG-1:0] stg_range(input int lo, input int hi);
    logic [NSTG-1:0] m;
    m = '0;
    for (int k = 0; k < NSTG; k++) begin
      if (k >= lo && k <= hi) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_stall_wdog.sv
// Bus-wait watchdog: counts consecutive mem stall cycles and pulses
// timeout_o on the TIMEOUT-th one, then restarts the count.
module pipe_stall_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic timeout_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       hit;

  assign hit       = stall_i && (cnt_q == LAST);
  assign timeout_o = hit && rst_n;

  always_comb begin
    cnt_d = '0;
    if (stall_i && !hit) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: prioritised stall/flush decode in RUN,
// plus a trap sequence that drains the pipe before redirecting to the vector.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_stallreq_i,
  input  logic        ex_stallreq_i,
  input  logic        mem_stallreq_i,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic        busy_o,
  output logic        bus_timeout_o
);

  state_e      state_q, state_d;
  logic [31:0] vec_q, vec_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_RUN: begin
        if (trap_req_i) begin
          state_d = ST_DRAIN;
          vec_d   = trap_vec_i;
        end
      end
      ST_DRAIN:    if (!mem_stallreq_i) state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Outputs are forced to zero while reset is asserted, independent of the clock.
  always_comb begin
    stall_o        = '0;
    flush_o        = '0;
    new_pc_o       = '0;
    new_pc_valid_o = 1'b0;
    busy_o         = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (mem_stallreq_i) begin
            stall_o = stg_range(STG_PC, STG_EXMEM);
            flush_o = stg_range(STG_MEMWB, STG_MEMWB);
          end else if (ex_stallreq_i) begin
            stall_o = stg_range(STG_PC, STG_IDEX);
            flush_o = stg_range(STG_EXMEM, STG_EXMEM);
          end else if (ex_branch_flag_i) begin
            flush_o        = stg_range(STG_IFID, STG_IDEX);
            new_pc_o       = ex_branch_addr_i;
            new_pc_valid_o = 1'b1;
          end else if (id_stallreq_i) begin
            stall_o = stg_range(STG_PC, STG_IFID);
            flush_o = stg_range(STG_IDEX, STG_IDEX);
          end
        end
        ST_DRAIN: begin
          busy_o = 1'b1;
          if (mem_stallreq_i) begin
            stall_o = stg_range(STG_PC, STG_IDEX);
            flush_o = stg_range(STG_EXMEM, STG_EXMEM);
          end else begin
            stall_o = stg_range(STG_PC, STG_IFID);
            flush_o = stg_range(STG_IDEX, STG_IDEX);
          end
        end
        ST_REDIRECT: begin
          busy_o         = 1'b1;
          flush_o        = stg_range(STG_IFID, STG_EXMEM);
          new_pc_o       = vec_q;
          new_pc_valid_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  pipe_stall_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_i  (mem_stallreq_i),
    .timeout_o(bus_timeout_o)
  );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of consecutive mem_stallreq_i cycles before bus_timeout_o pulses (range 1..255).
REQ-002 SHALL have ports, clock and reset first: clk in 1 (clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have id_stallreq_i in 1, the load-use hazard request from decode.
REQ-004 SHALL have ex_stallreq_i in 1, the multi-cycle execute busy request.
REQ-005 SHALL have mem_stallreq_i in 1, the data bus wait request.
REQ-006 SHALL have ex_branch_flag_i in 1 and ex_branch_addr_i in 32, the taken branch/jump and its target from execute.
REQ-007 SHALL have trap_req_i in 1 and trap_vec_i in 32, a single-cycle trap/interrupt request and its handler address.
REQ-008 SHALL have stall_o out 5, per-stage hold bits: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb.
REQ-009 SHALL have flush_o out 5, per-stage bubble-insert bits with the same indexing.
REQ-010 SHALL have new_pc_o out 32 and new_pc_valid_o out 1, the fetch redirect.
REQ-011 SHALL have busy_o out 1 (trap sequence in progress) and bus_timeout_o out 1 (one-cycle pulse).

Function
REQ-012 SHALL hold an FSM with states RUN, DRAIN and REDIRECT; all outputs except the FSM and counters are combinational from state and inputs.
REQ-013 In RUN, outputs SHALL be decided by the first true condition below (REQ-014..REQ-018).
REQ-014 mem_stallreq_i: stall_o=5'b01111, flush_o=5'b10000, no redirect.
REQ-015 ex_stallreq_i: stall_o=5'b00111, flush_o=5'b01000, no redirect.
REQ-016 ex_branch_flag_i: stall_o=0, flush_o=5'b00110, new_pc_o=ex_branch_addr_i, new_pc_valid_o=1; any same-cycle id_stallreq_i SHALL be ignored.
REQ-017 id_stallreq_i: stall_o=5'b00011, flush_o=5'b00100.
REQ-018 Otherwise: stall_o=0, flush_o=0, new_pc_valid_o=0.
REQ-019 trap_req_i in RUN SHALL latch trap_vec_i into a 32-bit register and move to DRAIN next cycle; the same-cycle outputs still follow REQ-014..REQ-018.
REQ-020 DRAIN SHALL drive stall_o=5'b00111 and flush_o=5'b01000 while mem_stallreq_i=1, otherwise stall_o=5'b00011 and flush_o=5'b00100; it SHALL go to REDIRECT on the first cycle with mem_stallreq_i=0.
REQ-021 REDIRECT SHALL last exactly one cycle: stall_o=0, flush_o=5'b01110, new_pc_o=latched vector, new_pc_valid_o=1; next state RUN.
REQ-022 busy_o SHALL be 1 in DRAIN and REDIRECT.
REQ-023 trap_req_i outside RUN SHALL be ignored; branches in DRAIN and REDIRECT SHALL be ignored, and the trap redirect wins.
REQ-024 An 8-bit counter SHALL increment on each cycle with mem_stallreq_i=1 and clear on any cycle with it 0.
REQ-025 When the counter equals TIMEOUT-1 with mem_stallreq_i=1, bus_timeout_o SHALL pulse for that one cycle and the counter SHALL clear; the counter SHALL saturate and never wrap silently.
REQ-026 stall_o[k] and flush_o[k] SHALL never both be 1 for the same k.

Reset
REQ-027 rst_n low SHALL asynchronously force state RUN, counter 0 and latched vector 0.
REQ-028 Reset SHALL force outputs stall_o=0, flush_o=0, new_pc_o=0, new_pc_valid_o=0, busy_o=0, bus_timeout_o=0.
REQ-029 Reset asserted mid-DRAIN or mid-REDIRECT SHALL abandon the trap with no redirect issued.

Structure
REQ-030 Stage index constants (STG_PC..STG_MEMWB), the FSM state encodings and the default TIMEOUT SHALL live in the shared defines file.
REQ-031 The watchdog counter SHALL be a sub-module pipe_stall_wdog.

Verification
REQ-032 mem_stallreq_i=1 with ex_branch_flag_i=1 -> stall_o=01111, flush_o=10000, new_pc_valid_o=0.
REQ-033 Branch to 0x0000_0100 alone -> flush_o=00110, new_pc_o=0x100, new_pc_valid_o=1 for one cycle.
REQ-034 trap_req_i with trap_vec_i=0x0000_0200 while mem_stallreq_i stays high 3 cycles -> busy_o high, DRAIN stall_o=00111 for those 3 cycles, then REDIRECT with new_pc_o=0x200 and flush_o=01110, then RUN.
REQ-035 TIMEOUT=4 with mem_stallreq_i held 9 cycles -> bus_timeout_o pulses in the 4th and 8th cycles only.
REQ-036 rst_n low during DRAIN -> all outputs 0 immediately; after release there is no redirect and state is RUN.
REQ-037 id_stallreq_i alone -> stall_o=00011, flush_o=00100; id_stallreq_i with a branch -> branch outputs only.
